// File: rtl/ahb2_sram_slv.sv
// ahb2_sram_slv: AHB2 slave backed by a flop word memory, with programmable wait states and two-cycle ERROR responses.
module ahb2_sram_slv #(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hready_out,
  output logic [1:0]  hresp
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
  state_t r_state, w_state_n;
  logic [31:0]       r_mem [2**MEM_AW];
  logic [MEM_AW+1:0] r_addr;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_dp;
  logic [3:0]        r_cnt;
  logic              w_acc, w_err, w_done, w_unused;
  logic [3:0]        w_be;
  assign w_unused = &{1'b0, hburst, hprot, haddr[31:MEM_AW+2], htrans[0]};
  assign w_acc = hsel & hready_in & htrans[1];
  assign w_err = (hsize > 3'd2) | (hsize == 3'd1 & haddr[0]) | (hsize == 3'd2 & |haddr[1:0]);
  // a pending OKAY data phase completes once the wait counter has drained back to IDLE
  assign w_done = r_dp & (r_state == S_IDLE);
  assign w_be = r_size == 2'd0 ? 4'b0001 << r_addr[1:0] :
                r_size == 2'd1 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE, S_ERR2: w_state_n = !w_acc ? S_IDLE : w_err ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_IDLE;
      S_WAIT:         w_state_n = r_cnt == 4'd1 ? S_IDLE : S_WAIT;
      S_ERR1:         w_state_n = S_ERR2;
      default:        w_state_n = S_IDLE;
    endcase
  end
  always_comb begin
    hready_out = r_state == S_IDLE || r_state == S_ERR2;
    hresp      = (r_state == S_ERR1 || r_state == S_ERR2) ? 2'b01 : 2'b00;
    hrdata     = (w_done & !r_write) ? r_mem[r_addr[MEM_AW+1:2]] : 32'h0;
  end
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 2'd0;
      r_dp    <= 1'b0;
      r_cnt   <= 4'd0;
    end else if (hready_out) begin
      r_dp  <= w_acc & !w_err;
      r_cnt <= 4'(WAIT_STATES);
      if (w_acc) begin
        r_addr  <= haddr[MEM_AW+1:0];
        r_write <= hwrite;
        r_size  <= hsize[1:0];
      end
    end else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
  always_ff @(posedge hclk)
    for (int b = 0; b < 4; b++)
      if (w_done & r_write & w_be[b]) r_mem[r_addr[MEM_AW+1:2]][8*b+:8] <= hwdata[8*b+:8];
endmodule

// File: tb/tb_ahb2_sram_slv.sv
// tb_ahb2_sram_slv: directed checks of a zero-wait and a two-wait instance of ahb2_sram_slv.
module tb_ahb2_sram_slv;
  logic        hclk = 1'b0, hreset = 1'b1, hsel = 1'b0, use2 = 1'b0, hwrite = 1'b0;
  logic        ovr = 1'b0, ovr_val = 1'b1;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd2;
  logic [31:0] hrdata0, hrdata2, rdata;
  logic        hready0, hready2, rdy;
  logic [1:0]  hresp0, hresp2, resp;
  int checks = 0, failures = 0;
  always #5 hclk = ~hclk;
  ahb2_sram_slv #(.MEM_AW(10), .WAIT_STATES(0)) u0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel & !use2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'h3), .hwdata(hwdata),
    .hready_in(ovr ? ovr_val : hready0), .hrdata(hrdata0), .hready_out(hready0), .hresp(hresp0));
  ahb2_sram_slv #(.MEM_AW(10), .WAIT_STATES(2)) u2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel & use2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'd1), .hprot(4'h3), .hwdata(hwdata),
    .hready_in(hready2), .hrdata(hrdata2), .hready_out(hready2), .hresp(hresp2));
  assign rdy   = use2 ? hready2 : hready0;
  assign resp  = use2 ? hresp2  : hresp0;
  assign rdata = use2 ? hrdata2 : hrdata0;
  task automatic step;
    @(posedge hclk); #1;
  endtask
  task automatic drv(input logic s, input logic [1:0] t, input logic w, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    hsel = s; htrans = t; hwrite = w; hsize = sz; haddr = a; hwdata = wd;
  endtask
  // one single transfer: address phase, then hold hwdata until the slave completes
  task automatic xfer(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] rs, output int waits);
    drv(1'b1, 2'b10, w, sz, a, 32'h0);
    step;
    drv(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, wd);
    waits = 0;
    rd = 'x;
    rs = 'x;
    while (waits < 20) begin
      @(negedge hclk);
      if (rdy) begin
        rd = rdata;
        rs = resp;
        break;
      end
      waits++;
      step;
    end
    if (waits >= 20) waits = 99;
    step;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    checks += 6;
    if (hready0 !== 1'b1) begin failures++; $display("FAIL rst_rdy0 got=%b exp=1", hready0); end
    if (hresp0 !== 2'b00) begin failures++; $display("FAIL rst_resp0 got=%b exp=00", hresp0); end
    if (hrdata0 !== 32'h0) begin failures++; $display("FAIL rst_rdata0 got=%h exp=0", hrdata0); end
    if (hready2 !== 1'b1) begin failures++; $display("FAIL rst_rdy2 got=%b exp=1", hready2); end
    if (hresp2 !== 2'b00) begin failures++; $display("FAIL rst_resp2 got=%b exp=00", hresp2); end
    if (hrdata2 !== 32'h0) begin failures++; $display("FAIL rst_rdata2 got=%h exp=0", hrdata2); end
    hreset = 1'b0;
    step;
  endtask
  task automatic test_back_to_back;
    use2 = 1'b0;
    drv(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h0);
    @(negedge hclk);
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_addr_rdy got=%b exp=1", rdy); end
    step;
    drv(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF);
    @(negedge hclk);
    checks += 2;
    if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_wr_rdy got=%b exp=1", rdy); end
    if (resp !== 2'b00) begin failures++; $display("FAIL b2b_wr_resp got=%b exp=00", resp); end
    step;
    drv(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge hclk);
    checks += 3;
    if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_rd_rdy got=%b exp=1", rdy); end
    if (resp !== 2'b00) begin failures++; $display("FAIL b2b_rd_resp got=%b exp=00", resp); end
    if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_rd_data got=%h exp=deadbeef", rdata); end
    step;
    @(negedge hclk);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL b2b_idle_rdata got=%h exp=0", rdata); end
    step;
  endtask
  task automatic test_byte_lanes;
    logic [31:0] rd;
    logic [1:0]  rs;
    int          w;
    use2 = 1'b0;
    xfer(1'b1, 3'd2, 32'h10, 32'h11223344, rd, rs, w);
    xfer(1'b1, 3'd0, 32'h13, 32'hAB5A5A5A, rd, rs, w);
    xfer(1'b0, 3'd2, 32'h10, 32'h0, rd, rs, w);
    checks++;
    if (rd !== 32'hAB223344) begin failures++; $display("FAIL byte3 got=%h exp=ab223344", rd); end
    xfer(1'b1, 3'd1, 32'h10, 32'hFFFF7788, rd, rs, w);
    xfer(1'b1, 3'd0, 32'h11, 32'h9999CD99, rd, rs, w);
    xfer(1'b0, 3'd2, 32'h10, 32'h0, rd, rs, w);
    checks++;
    if (rd !== 32'hAB22CD88) begin failures++; $display("FAIL half_byte1 got=%h exp=ab22cd88", rd); end
  endtask
  task automatic test_wait_states;
    logic [31:0] rd;
    logic [1:0]  rs;
    int          w;
    use2 = 1'b1;
    xfer(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, rd, rs, w);
    checks += 2;
    if (w !== 2) begin failures++; $display("FAIL ws_wr_waits got=%0d exp=2", w); end
    if (rs !== 2'b00) begin failures++; $display("FAIL ws_wr_resp got=%b exp=00", rs); end
    xfer(1'b0, 3'd2, 32'h20, 32'h0, rd, rs, w);
    checks += 3;
    if (w !== 2) begin failures++; $display("FAIL ws_rd_waits got=%0d exp=2", w); end
    if (rs !== 2'b00) begin failures++; $display("FAIL ws_rd_resp got=%b exp=00", rs); end
    if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL ws_rd_data got=%h exp=cafef00d", rd); end
  endtask
  task automatic test_error;
    use2 = 1'b1;
    drv(1'b1, 2'b10, 1'b1, 3'd1, 32'h21, 32'h0);
    step;
    drv(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'hFFFFFFFF);
    @(negedge hclk);
    checks += 2;
    if (rdy !== 1'b0) begin failures++; $display("FAIL mis_err1_rdy got=%b exp=0", rdy); end
    if (resp !== 2'b01) begin failures++; $display("FAIL mis_err1_resp got=%b exp=01", resp); end
    step;
    @(negedge hclk);
    checks += 2;
    if (rdy !== 1'b1) begin failures++; $display("FAIL mis_err2_rdy got=%b exp=1", rdy); end
    if (resp !== 2'b01) begin failures++; $display("FAIL mis_err2_resp got=%b exp=01", resp); end
    step;
    @(negedge hclk);
    checks++;
    if (resp !== 2'b00) begin failures++; $display("FAIL mis_after_resp got=%b exp=00", resp); end
    drv(1'b1, 2'b10, 1'b1, 3'd3, 32'h20, 32'h0);
    step;
    drv(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge hclk);
    checks += 2;
    if (rdy !== 1'b0) begin failures++; $display("FAIL sz3_err1_rdy got=%b exp=0", rdy); end
    if (resp !== 2'b01) begin failures++; $display("FAIL sz3_err1_resp got=%b exp=01", resp); end
    step;
    drv(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
    @(negedge hclk);
    checks += 2;
    if (rdy !== 1'b1) begin failures++; $display("FAIL sz3_err2_rdy got=%b exp=1", rdy); end
    if (resp !== 2'b01) begin failures++; $display("FAIL sz3_err2_resp got=%b exp=01", resp); end
    step;
    drv(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      checks++;
      if (rdy !== 1'b0) begin failures++; $display("FAIL err2_accept_wait%0d got=%b exp=0", i, rdy); end
      step;
    end
    @(negedge hclk);
    checks += 2;
    if (rdy !== 1'b1) begin failures++; $display("FAIL err2_accept_rdy got=%b exp=1", rdy); end
    if (rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL err_mem_kept got=%h exp=cafef00d", rdata); end
    step;
  endtask
  task automatic test_burst_gaps;
    logic [31:0] rd;
    logic [1:0]  rs;
    int          w;
    logic [1:0]  tr [6] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
    logic        sl [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad [6] = '{32'h40, 32'h44, 32'h44, 32'h48, 32'h48, 32'h48};
    logic [31:0] wd [6] = '{32'h0, 32'hA0A0A0A0, 32'h0BAD0BAD, 32'hA4A4A4A4, 32'h0BAD0BAD, 32'h0BAD0BAD};
    use2 = 1'b0;
    xfer(1'b1, 3'd2, 32'h48, 32'h48484848, rd, rs, w);
    for (int i = 0; i < 6; i++) begin
      drv(sl[i], tr[i], 1'b1, 3'd2, ad[i], wd[i]);
      @(negedge hclk);
      checks++;
      if (rdy !== 1'b1 || resp !== 2'b00) begin
        failures++; $display("FAIL gap_cyc%0d rdy/resp got=%b/%b exp=1/00", i, rdy, resp);
      end
      step;
    end
    xfer(1'b0, 3'd2, 32'h40, 32'h0, rd, rs, w);
    checks++;
    if (rd !== 32'hA0A0A0A0) begin failures++; $display("FAIL gap_rd40 got=%h exp=a0a0a0a0", rd); end
    xfer(1'b0, 3'd2, 32'h44, 32'h0, rd, rs, w);
    checks++;
    if (rd !== 32'hA4A4A4A4) begin failures++; $display("FAIL gap_rd44 got=%h exp=a4a4a4a4", rd); end
    xfer(1'b0, 3'd2, 32'h48, 32'h0, rd, rs, w);
    checks++;
    if (rd !== 32'h48484848) begin failures++; $display("FAIL gap_rd48 got=%h exp=48484848", rd); end
  endtask
  task automatic test_hready_in_low;
    logic [31:0] rd;
    logic [1:0]  rs;
    int          w;
    use2 = 1'b0;
    ovr = 1'b1;
    ovr_val = 1'b0;
    drv(1'b1, 2'b10, 1'b1, 3'd2, 32'h48, 32'h0);
    step;
    ovr = 1'b0;
    drv(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'hBADBAD00);
    step;
    xfer(1'b0, 3'd2, 32'h48, 32'h0, rd, rs, w);
    checks++;
    if (rd !== 32'h48484848) begin failures++; $display("FAIL hrdy_in_ignored got=%h exp=48484848", rd); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] rd;
    logic [1:0]  rs;
    int          w;
    use2 = 1'b1;
    drv(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h0);
    step;
    drv(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h12345678);
    @(negedge hclk);
    checks++;
    if (rdy !== 1'b0) begin failures++; $display("FAIL rmid_wait_rdy got=%b exp=0", rdy); end
    #1 hreset = 1'b1;
    #1;
    checks += 2;
    if (rdy !== 1'b1) begin failures++; $display("FAIL rmid_rdy got=%b exp=1", rdy); end
    if (resp !== 2'b00) begin failures++; $display("FAIL rmid_resp got=%b exp=00", resp); end
    @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    step;
    xfer(1'b0, 3'd2, 32'h20, 32'h0, rd, rs, w);
    checks += 2;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL rmid_mem_kept got=%h exp=cafef00d", rd); end
    if (w !== 2) begin failures++; $display("FAIL rmid_waits got=%0d exp=2", w); end
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_byte_lanes;
    test_wait_states;
    test_error;
    test_burst_gaps;
    test_hready_in_low;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
